// File: rtl/lfsr_stream_cipher_ctrl.sv
// Keystream controller: owns a 128-bit Fibonacci LFSR, sequences seed load,
// warm-up discard and per-word keystream generation for XOR encryption.
module lfsr_stream_cipher_ctrl #(
    parameter int WARMUP = 256,
    parameter int DW     = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_seed_valid,
    input  logic [127:0]  i_seed,
    output logic          o_seed_ready,
    output logic          o_seed_err,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_data,
    output logic          o_in_ready,
    output logic          o_out_valid,
    output logic [DW-1:0] o_out_data,
    input  logic          i_out_ready,
    output logic          o_busy,
    output logic [127:0]  o_lfsr
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [BCW-1:0] BLAST = BCW'(DW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_READY,
        ST_GEN,
        ST_OUT
    } state_t;

    state_t         state, state_nxt;
    logic [127:0]   lfsr, lfsr_step;
    logic [WCW-1:0] wcnt;
    logic [BCW-1:0] bcnt;
    logic [DW-1:0]  acc, acc_nxt, data_q, out_q;
    logic           seed_err_q, seed_acc, seed_zero, in_acc;

    assign lfsr_step = {lfsr[127] ^ lfsr[6] ^ lfsr[1] ^ lfsr[0], lfsr[127:1]};
    assign seed_zero = (i_seed == '0);
    assign seed_acc  = i_seed_valid && o_seed_ready;
    assign in_acc    = i_in_valid && o_in_ready;

    // Keystream bit for the current shift lands at accumulator position bcnt
    always_comb begin
        acc_nxt       = acc;
        acc_nxt[bcnt] = lfsr[0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_READY: begin
                if (i_seed_valid) begin
                    if (seed_zero)        state_nxt = ST_IDLE;
                    else if (WARMUP == 0) state_nxt = ST_READY;
                    else                  state_nxt = ST_WARMUP;
                end else if (state == ST_READY && i_in_valid) begin
                    state_nxt = ST_GEN;
                end
            end
            ST_WARMUP: if (wcnt == WLAST) state_nxt = ST_READY;
            ST_GEN:    if (bcnt == BLAST) state_nxt = ST_OUT;
            ST_OUT:    if (i_out_ready)   state_nxt = ST_READY;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_seed_ready = (state == ST_IDLE) || (state == ST_READY);
        o_in_ready   = (state == ST_READY) && !i_seed_valid;
        o_out_valid  = (state == ST_OUT);
        o_busy       = (state == ST_WARMUP) || (state == ST_GEN) || (state == ST_OUT);
    end

    assign o_seed_err = seed_err_q;
    assign o_out_data = out_q;
    assign o_lfsr     = lfsr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr       <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            acc        <= '0;
            data_q     <= '0;
            out_q      <= '0;
            seed_err_q <= 1'b0;
        end else begin
            seed_err_q <= seed_acc && seed_zero;
            if (seed_acc && !seed_zero) begin
                lfsr <= i_seed;
                wcnt <= '0;
            end else if (state == ST_WARMUP) begin
                lfsr <= lfsr_step;
                wcnt <= wcnt + WCW'(1);
            end else if (in_acc) begin
                data_q <= i_in_data;
                acc    <= '0;
                bcnt   <= '0;
            end else if (state == ST_GEN) begin
                lfsr <= lfsr_step;
                acc  <= acc_nxt;
                bcnt <= bcnt + BCW'(1);
                if (bcnt == BLAST) out_q <= data_q ^ acc_nxt;
            end
        end
    end

endmodule
